// File: rtl/board_pkg.sv
// Board-wide constants and shared encodings for the measurement blocks.
package board_pkg;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int          FM_CNT_W    = 27;

  typedef enum logic [0:0] {
    FM_IDLE = 1'b0,
    FM_GATE = 1'b1
  } fm_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus rising-edge detector for slow asynchronous inputs.
// This block is also used for buttons and switches.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's old value; blocking would collapse the chain.
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over back-to-back GATE_CYCLES windows of clk_in.
// Define FREQ_METER_PERIOD_MEAS_EN to add period_out (clk_in cycles between the last two edges).
module freq_meter
  import board_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = CLK_FREQ_HZ,
  parameter int          CNT_W       = FM_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             meas_valid,
  output logic             overflow
`ifdef FREQ_METER_PERIOD_MEAS_EN
  ,
  output logic [CNT_W-1:0] period_out
`endif
);

  // The gate counter is sized from the window length. This lets a narrow CNT_W still run a long window.
  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  fm_state_t        state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt;
  logic             sat, sat_nxt;
  logic             edge_pulse;

  sync_edge_detect u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .rise   (edge_pulse)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    if (edge_pulse) begin
      if (edge_cnt == CNT_MAX) sat_nxt = 1'b1;
      else                     edge_cnt_nxt = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= FM_IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_out   <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        FM_IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (en) state <= FM_GATE;
        end
        FM_GATE: begin
          if (!en) begin
            // The partial window is dropped and the published result is left untouched.
            state    <= FM_IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            // An edge arriving in the closing cycle still belongs to this window.
            freq_out   <= edge_cnt_nxt;
            overflow   <= sat_nxt;
            meas_valid <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_cnt_nxt;
            sat      <= sat_nxt;
          end
        end
        default: state <= FM_IDLE;
      endcase
    end
  end

`ifdef FREQ_METER_PERIOD_MEAS_EN
  logic [CNT_W-1:0] period_cnt;
  logic             have_prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      have_prev  <= 1'b0;
      period_out <= '0;
    end else if (!en || state == FM_IDLE) begin
      period_cnt <= '0;
      have_prev  <= 1'b0;
    end else if (edge_pulse) begin
      // The first edge after enabling only starts the interval.
      if (have_prev) period_out <= period_cnt;
      period_cnt <= CNT_W'(1);
      have_prev  <= 1'b1;
    end else if (period_cnt != CNT_MAX) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter.
// It runs a wide instance and a saturating narrow instance side by side on shared stimulus.
module tb_freq_meter;

  localparam int G     = 1000;
  localparam int N_MAX = 63;

  typedef enum int {DRV_MANUAL, DRV_HOLD, DRV_PERIOD, DRV_RANDOM} drv_t;
  typedef struct {
    drv_t mode;
    int   arg;
    int   raw;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst, en, sig_in;
  logic [11:0] freq_w;
  logic [5:0]  freq_n;
  logic        valid_w, valid_n, ovf_w, ovf_n;
`ifdef FREQ_METER_PERIOD_MEAS_EN
  logic [11:0] period_w;
  logic [5:0]  period_n;
`endif

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  bit   xs [0:65535];
  drv_t drv_mode = DRV_MANUAL;
  int   drv_arg = 1;
  bit   man_val = 1'b0;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(12)) dut_w (
    .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(freq_w), .meas_valid(valid_w), .overflow(ovf_w)
`ifdef FREQ_METER_PERIOD_MEAS_EN
    , .period_out(period_w)
`endif
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(6)) dut_n (
    .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(freq_n), .meas_valid(valid_n), .overflow(ovf_n)
`ifdef FREQ_METER_PERIOD_MEAS_EN
    , .period_out(period_n)
`endif
  );

  always #5 clk_in = ~clk_in;

  // History of sig_in as seen by the first synchronizer flop (held low while in reset).
  always @(posedge clk_in) begin
    cyc         <= cyc + 1;
    xs[cyc + 1] <= rst ? 1'b0 : sig_in;
  end

  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk_in);
      #1;
      case (drv_mode)
        DRV_HOLD:   sig_in = drv_arg[0];
        DRV_PERIOD: sig_in = (cyc % drv_arg) < (drv_arg / 2);
        DRV_RANDOM: sig_in = ($urandom_range(drv_arg - 1, 0) == 0);
        default:    sig_in = man_val;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Edges in window w are the sampled 0->1 transitions, counted two edges later by the meter.
  function automatic int raw_count(input int e0, input int w);
    int r = 0;
    for (int k = e0 + 1 + w * G; k <= e0 + (w + 1) * G; k++)
      if (xs[k - 2] && !xs[k - 3]) r++;
    return r;
  endfunction

  task automatic expect_window(input int e0, input int w, input int exp_raw,
                               input int set_at, input bit set_val, input string name);
    int target, spurious, raw, sat_raw;
    target   = e0 + (w + 1) * G;
    spurious = 0;
    while (cyc < target) begin
      @(negedge clk_in);
      if (cyc == set_at) man_val = set_val;
      if ((valid_w || valid_n) && cyc != target) spurious++;
    end
    raw     = (exp_raw < 0) ? raw_count(e0, w) : exp_raw;
    sat_raw = (raw > N_MAX) ? N_MAX : raw;
    check({name, ".spurious"}, spurious, 0);
    check({name, ".valid"}, {valid_n, valid_w}, 2'b11);
    check({name, ".freq"}, freq_w, raw);
    check({name, ".ovf"}, ovf_w, 0);
    check({name, ".freq_n"}, freq_n, sat_raw);
    check({name, ".ovf_n"}, ovf_n, raw > N_MAX);
  endtask

  task automatic check_zero(input string name);
    check({name, ".freq"}, freq_w, 0);
    check({name, ".valid"}, {valid_n, valid_w}, 0);
    check({name, ".ovf"}, {ovf_n, ovf_w}, 0);
    check({name, ".freq_n"}, freq_n, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int e0, w, spurious, stop_at;

    tbl[0] = '{DRV_PERIOD, 10, 100};
    tbl[1] = '{DRV_HOLD, 0, 0};
    tbl[2] = '{DRV_HOLD, 1, 0};
    tbl[3] = '{DRV_PERIOD, 20, 50};
    tbl[4] = '{DRV_PERIOD, 4, 250};
    tbl[5] = '{DRV_PERIOD, 2, 500};
    tbl[6] = '{DRV_PERIOD, 1000, 1};
    tbl[7] = '{DRV_PERIOD, 8, 125};

    rst = 1'b1;
    en  = 1'b0;
    repeat (5) @(negedge clk_in);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check_zero("idle");

    // Table: the first window after each change is checked against the model, the second against the constant.
    en = 1'b1;
    e0 = cyc + 1;
    w  = 0;
    for (int i = 0; i < 8; i++) begin
      drv_mode = tbl[i].mode;
      drv_arg  = tbl[i].arg;
      expect_window(e0, w, -1, -1, 1'b0, $sformatf("tbl%0d.enter", i));
      w++;
      expect_window(e0, w, tbl[i].raw, -1, 1'b0, $sformatf("tbl%0d", i));
      w++;
    end

    // Edge landing on the window-end cycle, then one cycle later.
    drv_mode = DRV_MANUAL;
    man_val  = 1'b0;
    expect_window(e0, w, -1, -1, 1'b0, "bnd.settle");
    w++;
    expect_window(e0, w, 1, e0 + (w + 1) * G - 3, 1'b1, "bnd.on_end");
    w++;
    expect_window(e0, w, 0, e0 + w * G + 500, 1'b0, "bnd.on_end_next");
    w++;
    expect_window(e0, w, 0, e0 + (w + 1) * G - 2, 1'b1, "bnd.after_end");
    w++;
    expect_window(e0, w, 1, -1, 1'b0, "bnd.after_end_next");
    w++;

    // en dropped at gate_cnt=500 and raised 20 cycles later.
    drv_mode = DRV_PERIOD;
    drv_arg  = 10;
    expect_window(e0, w, -1, -1, 1'b0, "abort.settle");
    w++;
    expect_window(e0, w, 100, -1, 1'b0, "abort.pre");
    w++;
    stop_at  = e0 + w * G + 500;
    spurious = 0;
    while (cyc < stop_at) begin
      @(negedge clk_in);
      if (valid_w || valid_n) spurious++;
    end
    en = 1'b0;
    repeat (20) begin
      @(negedge clk_in);
      if (valid_w || valid_n) spurious++;
    end
    check("abort.spurious", spurious, 0);
    check("abort.hold", freq_w, 100);
    en = 1'b1;
    e0 = cyc + 1;
    expect_window(e0, 0, -1, -1, 1'b0, "reen.first");
    expect_window(e0, 1, 100, -1, 1'b0, "reen.second");
    w = 2;

    // Reset asserted mid-window clears the outputs at once.
    stop_at = e0 + w * G + 300;
    while (cyc < stop_at) @(negedge clk_in);
    rst = 1'b1;
    #1;
    check_zero("rst.async");
    spurious = 0;
    repeat (5) begin
      @(negedge clk_in);
      if (valid_w || valid_n) spurious++;
    end
    check("rst.spurious", spurious, 0);
    rst = 1'b0;
    e0  = cyc + 1;
    expect_window(e0, 0, -1, -1, 1'b0, "rst.first");
    expect_window(e0, 1, 100, -1, 1'b0, "rst.second");
    w = 2;

    // Random stimulus: dense (narrow instance saturates) and sparse (near the narrow limit).
    drv_mode = DRV_RANDOM;
    drv_arg  = 4;
    for (int i = 0; i < 2; i++) begin
      expect_window(e0, w, -1, -1, 1'b0, $sformatf("rnd4.%0d", i));
      w++;
    end
    drv_arg = 16;
    for (int i = 0; i < 4; i++) begin
      expect_window(e0, w, -1, -1, 1'b0, $sformatf("rnd16.%0d", i));
      w++;
    end

`ifdef FREQ_METER_PERIOD_MEAS_EN
    drv_mode = DRV_PERIOD;
    drv_arg  = 37;
    expect_window(e0, w, -1, -1, 1'b0, "per37");
    w++;
    check("per37.period", period_w, 37);
    check("per37.period_n", period_n, 37);
    drv_arg = 1000;
    expect_window(e0, w, -1, -1, 1'b0, "per1000.a");
    w++;
    expect_window(e0, w, 1, -1, 1'b0, "per1000.b");
    w++;
    check("per1000.period", period_w, 1000);
    check("per1000.period_n", period_n, N_MAX);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
